gerenciador_processos: RTL and testbench

- Parametrised process/context manager for the single-cycle CPU. It supersedes the fixed quantum counter and the single processo_atual register.
- Holds per-process state (ready/blocked flags and saved PC) for NUM_PROC processes; process 0 is the kernel/scheduler.
- Counts the quantum per executed instruction and redirects the PC to the scheduler or the IO handler.
- Provides the round-robin next-process choice to the scheduler code.

---
 rtl/gerenciador_pkg.sv | 11 +
 rtl/gerenciador_processos_arbitro.sv | 26 ++
 rtl/gerenciador_processos.sv | 177 +++++++++++++++++
 tb/tb_gerenciador_processos.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gerenciador_pkg.sv
// Shared types and defaults for the process/context manager.
package gerenciador_pkg;
  typedef enum logic {
    KERNEL     = 1'b0,
    EXECUTANDO = 1'b1
  } estado_t;

  localparam int END_ESCALONADOR_DEF = 1;
  localparam int END_IO_DEF          = 92;
  localparam int KERNEL_PROC         = 0;
endpackage

// File: rtl/gerenciador_processos_arbitro.sv
// Round-robin pick: first request after 'inicio', wrapping; 'inicio' itself is tried last.
module arbitro_round_robin #(
  parameter int NUM_PROC = 8,
  parameter int PROC_W   = $clog2(NUM_PROC)
) (
  input  logic [NUM_PROC-1:0] req,
  input  logic [PROC_W-1:0]   inicio,
  output logic [PROC_W-1:0]   concedido,
  output logic                nenhum
);
  logic [PROC_W-1:0] idx;

  // Walk from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    concedido = '0;
    nenhum    = 1'b1;
    idx       = '0;
    for (int i = NUM_PROC; i >= 1; i--) begin
      idx = PROC_W'((int'(inicio) + i) % NUM_PROC);
      if (req[idx]) begin
        concedido = idx;
        nenhum    = 1'b0;
      end
    end
  end
endmodule

// File: rtl/gerenciador_processos.sv
// Process/context manager: per-process ready/blocked/saved-PC table, quantum
// counting and zero-latency PC redirects to the scheduler or IO handler.
module gerenciador_processos
  import gerenciador_pkg::*;
#(
  parameter int NUM_PROC        = 8,
  parameter int PC_W            = 32,
  parameter int QUANTUM         = 16,
  parameter int END_ESCALONADOR = END_ESCALONADOR_DEF,
  parameter int END_IO          = END_IO_DEF,
  parameter int PROC_W          = $clog2(NUM_PROC),
  localparam int QW             = $clog2(QUANTUM + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic [PC_W-1:0]     pc,
  input  logic                instr_io,
  input  logic                fim_processo,
  input  logic                carrega,
  input  logic [PROC_W-1:0]   proc_carrega,
  input  logic                cria,
  input  logic [PROC_W-1:0]   cria_proc,
  input  logic [PC_W-1:0]     cria_pc,
  input  logic                io_concluido,
  input  logic [PROC_W-1:0]   io_proc,
  output logic                troca_contexto,
  output logic                desvio_io,
  output logic [PC_W-1:0]     pc_destino,
  output logic [PC_W-1:0]     pc_salvo,
  output logic [PROC_W-1:0]   processo_atual,
  output logic [NUM_PROC-1:0] proc_pronto,
  output logic [NUM_PROC-1:0] proc_bloqueado,
  output logic [PROC_W-1:0]   proximo_proc,
  output logic                nenhum_pronto,
  output logic [QW-1:0]       quantum_restante,
  output logic                erro
);
  localparam logic [PROC_W-1:0] KPROC = PROC_W'(KERNEL_PROC);

  estado_t                       estado_q, estado_d;
  logic [PROC_W-1:0]             atual_q, atual_d;
  logic [PROC_W-1:0]             ultimo_q, ultimo_d;
  logic [QW-1:0]                 quantum_q, quantum_d;
  logic [NUM_PROC-1:0]           pronto_q, pronto_d;
  logic [NUM_PROC-1:0]           bloq_q, bloq_d;
  logic [NUM_PROC-1:0][PC_W-1:0] tabela_q, tabela_d;
  logic                          erro_q, erro_d;

  logic executando, ev_fim, ev_io, ev_expira;
  logic carrega_idx_ok, cria_ok, io_idx_ok;
  logic [PROC_W-1:0]   arb_inicio;
  logic [NUM_PROC-1:0] arb_req;

  assign executando = (estado_q == EXECUTANDO) && habilita;
  assign ev_fim     = executando && fim_processo;
  assign ev_io      = executando && !fim_processo && instr_io;
  assign ev_expira  = executando && !fim_processo && !instr_io && (quantum_q == '0);

  assign carrega_idx_ok = int'(proc_carrega) < NUM_PROC;
  assign io_idx_ok      = int'(io_proc) < NUM_PROC;
  assign cria_ok        = (int'(cria_proc) < NUM_PROC) && (cria_proc != KPROC)
                          && (cria_proc != atual_q);

  assign troca_contexto = ev_fim || ev_expira;
  assign desvio_io      = ev_io;
  assign pc_destino     = troca_contexto ? PC_W'(END_ESCALONADOR) :
                          desvio_io      ? PC_W'(END_IO) : '0;
  assign pc_salvo       = carrega_idx_ok ? tabela_q[proc_carrega] : '0;

  // Slot 0 is never a candidate; in kernel the search resumes after the last dispatch.
  assign arb_req    = pronto_q & ~NUM_PROC'(1);
  assign arb_inicio = (estado_q == EXECUTANDO) ? atual_q : ultimo_q;

  arbitro_round_robin #(
    .NUM_PROC (NUM_PROC),
    .PROC_W   (PROC_W)
  ) u_arbitro (
    .req       (arb_req),
    .inicio    (arb_inicio),
    .concedido (proximo_proc),
    .nenhum    (nenhum_pronto)
  );

  // Lowest-priority writes first so same-slot conflicts resolve FSM > cria > io_concluido.
  always_comb begin
    estado_d  = estado_q;
    atual_d   = atual_q;
    ultimo_d  = ultimo_q;
    quantum_d = quantum_q;
    pronto_d  = pronto_q;
    bloq_d    = bloq_q;
    tabela_d  = tabela_q;
    erro_d    = 1'b0;

    if (io_concluido && io_idx_ok && bloq_q[io_proc]) begin
      bloq_d[io_proc]   = 1'b0;
      pronto_d[io_proc] = 1'b1;
    end

    if (cria) begin
      if (cria_ok) begin
        pronto_d[cria_proc] = 1'b1;
        bloq_d[cria_proc]   = 1'b0;
        tabela_d[cria_proc] = cria_pc;
      end else begin
        erro_d = 1'b1;
      end
    end

    case (estado_q)
      KERNEL: begin
        if (carrega) begin
          if (carrega_idx_ok && proc_carrega != KPROC && pronto_q[proc_carrega]) begin
            estado_d  = EXECUTANDO;
            atual_d   = proc_carrega;
            ultimo_d  = proc_carrega;
            quantum_d = QW'(QUANTUM);
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      EXECUTANDO: begin
        if (ev_fim) begin
          pronto_d[atual_q] = 1'b0;
          estado_d  = KERNEL;
          atual_d   = KPROC;
          quantum_d = '0;
        end else if (ev_io) begin
          tabela_d[atual_q] = pc + PC_W'(1);
          pronto_d[atual_q] = 1'b0;
          bloq_d[atual_q]   = 1'b1;
          estado_d  = KERNEL;
          atual_d   = KPROC;
          quantum_d = '0;
        end else if (ev_expira) begin
          // The instruction at pc never committed, so it is retried on resume.
          tabela_d[atual_q] = pc;
          estado_d = KERNEL;
          atual_d  = KPROC;
        end else if (executando) begin
          quantum_d = quantum_q - QW'(1);
        end
      end
      default: estado_d = KERNEL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= KERNEL;
      atual_q   <= '0;
      ultimo_q  <= '0;
      quantum_q <= '0;
      pronto_q  <= '0;
      bloq_q    <= '0;
      tabela_q  <= '0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      atual_q   <= atual_d;
      ultimo_q  <= ultimo_d;
      quantum_q <= quantum_d;
      pronto_q  <= pronto_d;
      bloq_q    <= bloq_d;
      tabela_q  <= tabela_d;
      erro_q    <= erro_d;
    end
  end

  assign processo_atual   = atual_q;
  assign proc_pronto      = pronto_q;
  assign proc_bloqueado   = bloq_q;
  assign quantum_restante = quantum_q;
  assign erro             = erro_q;
endmodule

// File: tb/tb_gerenciador_processos.sv
// Bench for gerenciador_processos (NUM_PROC=4, QUANTUM=4): vector table,
// directed corner sequences and random traffic against a behavioural model.
module tb_gerenciador_processos;
  localparam int NP = 4;
  localparam int QT = 4;
  localparam int PW = 2;
  localparam int QW = 3;

  logic          clock = 1'b0;
  logic          reset, habilita, instr_io, fim_processo, carrega, cria, io_concluido;
  logic [31:0]   pc, cria_pc;
  logic [PW-1:0] proc_carrega, cria_proc, io_proc;
  logic          troca_contexto, desvio_io, nenhum_pronto, erro;
  logic [31:0]   pc_destino, pc_salvo;
  logic [PW-1:0] processo_atual, proximo_proc;
  logic [NP-1:0] proc_pronto, proc_bloqueado;
  logic [QW-1:0] quantum_restante;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  gerenciador_processos #(.NUM_PROC(NP), .PC_W(32), .QUANTUM(QT)) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .pc(pc),
    .instr_io(instr_io), .fim_processo(fim_processo), .carrega(carrega),
    .proc_carrega(proc_carrega), .cria(cria), .cria_proc(cria_proc),
    .cria_pc(cria_pc), .io_concluido(io_concluido), .io_proc(io_proc),
    .troca_contexto(troca_contexto), .desvio_io(desvio_io),
    .pc_destino(pc_destino), .pc_salvo(pc_salvo),
    .processo_atual(processo_atual), .proc_pronto(proc_pronto),
    .proc_bloqueado(proc_bloqueado), .proximo_proc(proximo_proc),
    .nenhum_pronto(nenhum_pronto), .quantum_restante(quantum_restante),
    .erro(erro)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_rdy[NP];
  bit          m_blk[NP];
  logic [31:0] m_tab[NP];
  int          m_run, m_last, m_rem;
  bit          m_err;

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_rdy[i] = 0; m_blk[i] = 0; m_tab[i] = '0;
    end
    m_run = 0; m_last = 0; m_rem = 0; m_err = 0;
  endtask

  function automatic logic [31:0] pack(input bit v[NP]);
    logic [31:0] r = '0;
    for (int i = 0; i < NP; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic compare_model(input string tag);
    bit tr, dv, ex, none;
    int start, prox;
    ex = (m_run != 0) && habilita;
    tr = ex && (fim_processo || (!instr_io && m_rem == 0));
    dv = ex && !fim_processo && instr_io;
    start = (m_run != 0) ? m_run : m_last;
    prox = 0; none = 1;
    for (int k = 1; k <= NP; k++) begin
      int s = (start + k) % NP;
      if (none && s != 0 && m_rdy[s]) begin prox = s; none = 0; end
    end
    chk({tag, ".troca"}, 32'(troca_contexto), 32'(tr));
    chk({tag, ".desvio"}, 32'(desvio_io), 32'(dv));
    chk({tag, ".destino"}, pc_destino, tr ? 32'd1 : dv ? 32'd92 : 32'd0);
    chk({tag, ".salvo"}, pc_salvo, m_tab[proc_carrega]);
    chk({tag, ".atual"}, 32'(processo_atual), 32'(m_run));
    chk({tag, ".pronto"}, 32'(proc_pronto), pack(m_rdy));
    chk({tag, ".bloq"}, 32'(proc_bloqueado), pack(m_blk));
    chk({tag, ".prox"}, 32'(proximo_proc), 32'(prox));
    chk({tag, ".nenhum"}, 32'(nenhum_pronto), 32'(none));
    chk({tag, ".erro"}, 32'(erro), 32'(m_err));
    if (m_run != 0) chk({tag, ".quantum"}, 32'(quantum_restante), 32'(m_rem));
  endtask

  task automatic model_update();
    bit          n_rdy[NP], n_blk[NP];
    logic [31:0] n_tab[NP];
    int          n_run, n_last, n_rem, r;
    bit          n_err;
    if (reset) begin model_reset(); return; end
    n_rdy = m_rdy; n_blk = m_blk; n_tab = m_tab;
    n_run = m_run; n_last = m_last; n_rem = m_rem; n_err = 0;
    r = m_run;
    if (io_concluido && m_blk[io_proc]) begin
      n_blk[io_proc] = 0; n_rdy[io_proc] = 1;
    end
    if (cria) begin
      if (cria_proc == 0 || int'(cria_proc) == m_run) n_err = 1;
      else begin n_rdy[cria_proc] = 1; n_blk[cria_proc] = 0; n_tab[cria_proc] = cria_pc; end
    end
    if (m_run == 0) begin
      if (carrega) begin
        if (proc_carrega != 0 && m_rdy[proc_carrega]) begin
          n_run = proc_carrega; n_last = proc_carrega; n_rem = QT;
        end else n_err = 1;
      end
    end else if (habilita) begin
      if (fim_processo) begin
        n_rdy[r] = 0; n_run = 0; n_rem = 0;
      end else if (instr_io) begin
        n_tab[r] = pc + 32'd1; n_rdy[r] = 0; n_blk[r] = 1; n_run = 0; n_rem = 0;
      end else if (m_rem == 0) begin
        n_tab[r] = pc; n_run = 0;
      end else n_rem = m_rem - 1;
    end
    m_rdy = n_rdy; m_blk = n_blk; m_tab = n_tab;
    m_run = n_run; m_last = n_last; m_rem = n_rem; m_err = n_err;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    reset = 0; habilita = 0; pc = '0; instr_io = 0; fim_processo = 0;
    carrega = 0; proc_carrega = '0; cria = 0; cria_proc = '0; cria_pc = '0;
    io_concluido = 0; io_proc = '0;
  endtask

  task automatic tick();
    @(negedge clock);
    compare_model("mdl");
    model_update();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); idle();
  endtask

  task automatic do_cria(input int p, input logic [31:0] a);
    idle(); cria = 1; cria_proc = PW'(p); cria_pc = a; tick(); idle();
  endtask

  task automatic do_carrega(input int p);
    idle(); carrega = 1; proc_carrega = PW'(p); tick(); idle();
  endtask

  task automatic run(input int n, input logic [31:0] pc0);
    for (int i = 0; i < n; i++) begin
      idle(); habilita = 1; pc = pc0 + 32'(i); tick();
    end
    idle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int rst, hab, pc, fim, io, car, pcar, cr, crp, crpc;
    int troca, dest, salvo, atual, pronto, prox, nenhum, quant, erro;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // rst hab pc fim io car pcar cr crp crpc | troca dest salvo atual pronto prox nenhum quant erro
    vecs[0]  = '{1, 0, 0,      0, 0, 0, 0, 0, 0, 0,       0, 0, 0,      0, 0, 0, 1, 0, 0};
    vecs[1]  = '{0, 0, 0,      0, 0, 0, 0, 1, 1, 'h200,   0, 0, 0,      0, 0, 0, 1, 0, 0};
    vecs[2]  = '{0, 0, 0,      0, 0, 1, 1, 0, 0, 0,       0, 0, 'h200,  0, 2, 1, 0, 0, 0};
    vecs[3]  = '{0, 1, 'h200,  0, 0, 0, 1, 0, 0, 0,       0, 0, 'h200,  1, 2, 1, 0, 4, 0};
    vecs[4]  = '{0, 1, 'h201,  0, 0, 0, 1, 0, 0, 0,       0, 0, 'h200,  1, 2, 1, 0, 3, 0};
    vecs[5]  = '{0, 1, 'h202,  0, 0, 0, 1, 0, 0, 0,       0, 0, 'h200,  1, 2, 1, 0, 2, 0};
    vecs[6]  = '{0, 1, 'h203,  0, 0, 0, 1, 0, 0, 0,       0, 0, 'h200,  1, 2, 1, 0, 1, 0};
    vecs[7]  = '{0, 1, 'h204,  0, 0, 0, 1, 0, 0, 0,       1, 1, 'h200,  1, 2, 1, 0, 0, 0};
    vecs[8]  = '{0, 0, 0,      0, 0, 0, 1, 0, 0, 0,       0, 0, 'h204,  0, 2, 1, 0, 0, 0};
    vecs[9]  = '{0, 0, 0,      0, 0, 1, 0, 0, 0, 0,       0, 0, 0,      0, 2, 1, 0, 0, 0};
    vecs[10] = '{0, 0, 0,      0, 0, 0, 0, 0, 0, 0,       0, 0, 0,      0, 2, 1, 0, 0, 1};
    vecs[11] = '{0, 0, 0,      0, 0, 1, 2, 0, 0, 0,       0, 0, 0,      0, 2, 1, 0, 0, 0};
    vecs[12] = '{0, 0, 0,      0, 0, 0, 2, 0, 0, 0,       0, 0, 0,      0, 2, 1, 0, 0, 1};
    vecs[13] = '{0, 0, 0,      0, 0, 0, 2, 0, 0, 0,       0, 0, 0,      0, 2, 1, 0, 0, 0};
    vecs[14] = '{0, 0, 0,      0, 0, 0, 0, 1, 0, 'h777,   0, 0, 0,      0, 2, 1, 0, 0, 0};
    vecs[15] = '{0, 0, 0,      0, 0, 0, 0, 0, 0, 0,       0, 0, 0,      0, 2, 1, 0, 0, 1};

    idle();
    model_reset();
    reset = 1;
    @(posedge clock); #1;
    @(posedge clock); #1;

    for (int i = 0; i < 16; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      idle();
      reset = vecs[i].rst[0]; habilita = vecs[i].hab[0]; pc = vecs[i].pc;
      fim_processo = vecs[i].fim[0]; instr_io = vecs[i].io[0];
      carrega = vecs[i].car[0]; proc_carrega = PW'(vecs[i].pcar);
      cria = vecs[i].cr[0]; cria_proc = PW'(vecs[i].crp); cria_pc = vecs[i].crpc;
      @(negedge clock);
      chk({t, ".troca"}, 32'(troca_contexto), vecs[i].troca);
      chk({t, ".destino"}, pc_destino, vecs[i].dest);
      chk({t, ".salvo"}, pc_salvo, vecs[i].salvo);
      chk({t, ".atual"}, 32'(processo_atual), vecs[i].atual);
      chk({t, ".pronto"}, 32'(proc_pronto), vecs[i].pronto);
      chk({t, ".prox"}, 32'(proximo_proc), vecs[i].prox);
      chk({t, ".nenhum"}, 32'(nenhum_pronto), vecs[i].nenhum);
      chk({t, ".quantum"}, 32'(quantum_restante), vecs[i].quant);
      chk({t, ".erro"}, 32'(erro), vecs[i].erro);
      model_update();
      @(posedge clock); #1;
    end
    idle();

    // Round robin across slots 1 and 3
    do_reset();
    do_cria(1, 32'h100);
    do_cria(3, 32'h300);
    do_carrega(1);
    run(QT + 1, 32'h100);
    #1 chk("rr.after1", 32'(proximo_proc), 32'd3);
    do_carrega(3);
    run(QT + 1, 32'h300);
    #1 chk("rr.after3", 32'(proximo_proc), 32'd1);
    do_carrega(1);
    habilita = 1; fim_processo = 1; tick(); idle();
    do_carrega(3);
    habilita = 1; fim_processo = 1; tick(); idle();
    #1 chk("rr.none.flag", 32'(nenhum_pronto), 32'd1);
    chk("rr.none.prox", 32'(proximo_proc), 32'd0);

    // IO trap, completion and redispatch
    do_reset();
    do_cria(2, 32'h300);
    do_carrega(2);
    habilita = 1; pc = 32'h310; instr_io = 1;
    #1 chk("io.desvio", 32'(desvio_io), 32'd1);
    chk("io.destino", pc_destino, 32'd92);
    chk("io.troca", 32'(troca_contexto), 32'd0);
    tick(); idle();
    proc_carrega = 2;
    #1 chk("io.bloq", 32'(proc_bloqueado), 32'b0100);
    chk("io.tabela", pc_salvo, 32'h311);
    chk("io.atual", 32'(processo_atual), 32'd0);
    io_concluido = 1; io_proc = 2; tick(); idle();
    #1 chk("io.pronto", 32'(proc_pronto), 32'b0100);
    carrega = 1; proc_carrega = 2;
    #1 chk("io.redispatch", pc_salvo, 32'h311);
    tick(); idle();

    // Halted CPU mid-slice: nothing moves, fim_processo ignored
    run(2, 32'h311);
    for (int i = 0; i < 10; i++) begin
      habilita = 0; pc = $urandom; fim_processo = (i % 3 == 0);
      #1 chk("halt.troca", 32'(troca_contexto), 32'd0);
      tick();
    end
    idle();
    #1 chk("halt.quantum", 32'(quantum_restante), 32'd2);
    chk("halt.atual", 32'(processo_atual), 32'd2);

    // fim_processo beats instr_io
    habilita = 1; fim_processo = 1; instr_io = 1; pc = 32'h313;
    #1 chk("fimio.troca", 32'(troca_contexto), 32'd1);
    chk("fimio.desvio", 32'(desvio_io), 32'd0);
    tick(); idle();
    #1 chk("fimio.pronto", 32'(proc_pronto), 32'd0);
    chk("fimio.bloq", 32'(proc_bloqueado), 32'd0);

    // Reset while a process is running
    do_cria(1, 32'h500);
    do_carrega(1);
    run(1, 32'h500);
    reset = 1; tick(); idle();
    #1 chk("rst.atual", 32'(processo_atual), 32'd0);
    chk("rst.pronto", 32'(proc_pronto), 32'd0);
    chk("rst.quantum", 32'(quantum_restante), 32'd0);
    chk("rst.nenhum", 32'(nenhum_pronto), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(299) == 0);
      habilita     = ($urandom_range(3) != 0);
      pc           = $urandom;
      fim_processo = ($urandom_range(15) == 0);
      instr_io     = ($urandom_range(9) == 0);
      carrega      = ($urandom_range(2) == 0);
      proc_carrega = PW'($urandom_range(3));
      cria         = ($urandom_range(5) == 0);
      cria_proc    = PW'($urandom_range(3));
      cria_pc      = $urandom;
      io_concluido = ($urandom_range(3) == 0);
      io_proc      = PW'($urandom_range(3));
      tick();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
